// File: rtl/debug_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debug_exec_ctrl
// Description : Debug run/step/halt controller for the MIPS pipeline. Streams
//               a full machine-state dump MSB first over the UART TX handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_exec_ctrl #(
    parameter int NUM_LATCH = 20,
    parameter int NUM_REGS  = 32,
    parameter int NUM_MEM   = 32,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_code,
    output logic        cmd_ready,
    input  logic        halt_detected,
    output logic        stop_debug,
    output logic        debug_on,
    output logic [6:0]  latch_sel,
    input  logic [31:0] latch_data,
    input  logic [31:0] pc,
    input  logic [31:0] reg_data,
    input  logic [31:0] mem_data,
    output logic [31:0] dbg_addr,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy
);

    localparam int c_TOTAL    = 1 + NUM_LATCH + NUM_REGS + NUM_MEM;
    localparam int c_REG_BASE = 1 + NUM_LATCH;
    localparam int c_MEM_BASE = c_REG_BASE + NUM_REGS;
    localparam int c_WW       = $clog2(c_TOTAL);
    localparam int c_CW       = $clog2(READ_LAT + 1);

    localparam logic [2:0] c_S_HALTED = 3'd0;
    localparam logic [2:0] c_S_RUN    = 3'd1;
    localparam logic [2:0] c_S_STEP   = 3'd2;
    localparam logic [2:0] c_S_D_SEL  = 3'd3;
    localparam logic [2:0] c_S_D_WAIT = 3'd4;
    localparam logic [2:0] c_S_D_BYTE = 3'd5;
    localparam logic [2:0] c_S_D_TXW  = 3'd6;

    localparam logic [7:0] c_CMD_RUN  = 8'h63;
    localparam logic [7:0] c_CMD_STEP = 8'h73;
    localparam logic [7:0] c_CMD_HALT = 8'h68;
    localparam logic [7:0] c_CMD_DUMP = 8'h64;

    logic [2:0]      r_state;
    logic [c_WW-1:0] r_wordIdx;
    logic [c_CW-1:0] r_waitCnt;
    logic [1:0]      r_byteCnt;
    logic [31:0]     r_shift;
    logic            w_cmdTake;
    logic [31:0]     w_src;

    assign w_cmdTake = cmd_valid && cmd_ready;

    // Word 0 is the PC, then latches, register file, data memory.
    always_comb begin
        w_src = pc;
        if (r_wordIdx == '0)
            w_src = pc;
        else if (r_wordIdx < c_WW'(c_REG_BASE))
            w_src = latch_data;
        else if (r_wordIdx < c_WW'(c_MEM_BASE))
            w_src = reg_data;
        else
            w_src = mem_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_S_HALTED;
            stop_debug <= 1'b1;
            cmd_ready  <= 1'b1;
            debug_on   <= 1'b0;
            busy       <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            latch_sel  <= 7'd0;
            dbg_addr   <= 32'd0;
            r_wordIdx  <= '0;
            r_waitCnt  <= '0;
            r_byteCnt  <= 2'd0;
            r_shift    <= 32'd0;
        end else begin
            tx_start <= 1'b0;
            case (r_state)
                c_S_HALTED: begin
                    if (w_cmdTake) begin
                        case (cmd_code)
                            c_CMD_RUN: begin
                                r_state    <= c_S_RUN;
                                stop_debug <= 1'b0;
                            end
                            c_CMD_STEP: begin
                                r_state    <= c_S_STEP;
                                stop_debug <= 1'b0;
                                cmd_ready  <= 1'b0;
                            end
                            c_CMD_DUMP: begin
                                r_state   <= c_S_D_SEL;
                                busy      <= 1'b1;
                                debug_on  <= 1'b1;
                                cmd_ready <= 1'b0;
                                r_wordIdx <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                c_S_RUN: begin
                    if (halt_detected || (w_cmdTake && cmd_code == c_CMD_HALT)) begin
                        r_state    <= c_S_D_SEL;
                        stop_debug <= 1'b1;
                        busy       <= 1'b1;
                        debug_on   <= 1'b1;
                        cmd_ready  <= 1'b0;
                        r_wordIdx  <= '0;
                    end
                end
                c_S_STEP: begin
                    r_state    <= c_S_D_SEL;
                    stop_debug <= 1'b1;
                    busy       <= 1'b1;
                    debug_on   <= 1'b1;
                    r_wordIdx  <= '0;
                end
                c_S_D_SEL: begin
                    if (r_wordIdx == '0) begin
                        // PC needs no selector; leave both selectors untouched.
                    end else if (r_wordIdx < c_WW'(c_REG_BASE))
                        latch_sel <= 7'(r_wordIdx - c_WW'(1));
                    else if (r_wordIdx < c_WW'(c_MEM_BASE))
                        dbg_addr <= 32'(r_wordIdx - c_WW'(c_REG_BASE));
                    else
                        dbg_addr <= 32'(r_wordIdx - c_WW'(c_MEM_BASE));
                    r_waitCnt <= c_CW'(READ_LAT);
                    r_state   <= c_S_D_WAIT;
                end
                c_S_D_WAIT: begin
                    if (r_waitCnt == '0) begin
                        r_shift   <= w_src;
                        r_byteCnt <= 2'd0;
                        r_state   <= c_S_D_BYTE;
                    end else begin
                        r_waitCnt <= r_waitCnt - c_CW'(1);
                    end
                end
                c_S_D_BYTE: begin
                    tx_data  <= r_shift[31:24];
                    tx_start <= 1'b1;
                    r_state  <= c_S_D_TXW;
                end
                c_S_D_TXW: begin
                    if (tx_done) begin
                        r_shift   <= {r_shift[23:0], 8'h00};
                        r_byteCnt <= r_byteCnt + 2'd1;
                        if (r_byteCnt != 2'd3) begin
                            r_state <= c_S_D_BYTE;
                        end else if (r_wordIdx == c_WW'(c_TOTAL - 1)) begin
                            r_state   <= c_S_HALTED;
                            busy      <= 1'b0;
                            debug_on  <= 1'b0;
                            cmd_ready <= 1'b1;
                        end else begin
                            r_wordIdx <= r_wordIdx + c_WW'(1);
                            r_state   <= c_S_D_SEL;
                        end
                    end
                end
                default: r_state <= c_S_HALTED;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_exec_ctrl
// Description : Directed scoreboard bench for debug_exec_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_exec_ctrl;

    localparam int NUM_LATCH   = 20;
    localparam int NUM_REGS    = 32;
    localparam int NUM_MEM     = 32;
    localparam int READ_LAT    = 1;
    localparam int TOTAL_BYTES = 4 * (1 + NUM_LATCH + NUM_REGS + NUM_MEM);

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic        cmd_ready;
    logic        halt_detected;
    logic        stop_debug;
    logic        debug_on;
    logic [6:0]  latch_sel;
    logic [31:0] latch_data;
    logic [31:0] pc;
    logic [31:0] reg_data;
    logic [31:0] mem_data;
    logic [31:0] dbg_addr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic        busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    // Pipeline debug taps: combinational latch mux, one-cycle register/memory reads.
    assign latch_data = 32'hA000_0000 | {25'd0, latch_sel};
    always @(posedge clk) begin
        reg_data <= {dbg_addr[29:0], 2'b00};
        mem_data <= ~dbg_addr;
    end

    debug_exec_ctrl #(
        .NUM_LATCH(NUM_LATCH), .NUM_REGS(NUM_REGS), .NUM_MEM(NUM_MEM), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_ready(cmd_ready), .halt_detected(halt_detected), .stop_debug(stop_debug),
        .debug_on(debug_on), .latch_sel(latch_sel), .latch_data(latch_data), .pc(pc),
        .reg_data(reg_data), .mem_data(mem_data), .dbg_addr(dbg_addr), .tx_data(tx_data),
        .tx_start(tx_start), .tx_done(tx_done), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) q.push_back(w[8*b +: 8]);
    endtask

    task automatic push_dump(input logic [31:0] pcv);
        push_word(pcv);
        for (int i = 0; i < NUM_LATCH; i++) push_word(32'hA000_0000 | 32'(i));
        for (int i = 0; i < NUM_REGS; i++) push_word(32'(i) * 32'd4);
        for (int i = 0; i < NUM_MEM; i++) push_word(~32'(i));
    endtask

    task automatic send_cmd(input logic [7:0] code);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_code  = code;
        check("cmd_ready_before_take", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Acts as the UART: answers each tx_start with tx_done two cycles later.
    task automatic collect(input int n);
        int got = 0;
        int cyc = 0;
        logic [7:0] e;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (tx_start) begin
                check("dump_flags", {28'd0, busy, debug_on, stop_debug, cmd_ready}, 32'hE);
                check("sb_depth", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("tx_byte", {24'd0, tx_data}, {24'd0, e});
                end
                got++;
                @(negedge clk);
                check("tx_start_pulse", {31'd0, tx_start}, 32'd0);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
        check("byte_count", 32'(got), 32'(n));
    endtask

    task automatic finish_checks();
        int extra = 0;
        check("sb_empty", 32'(q.size()), 32'd0);
        check("end_flags", {28'd0, busy, debug_on, stop_debug, cmd_ready}, 32'h3);
        check("hold_latch_sel", {25'd0, latch_sel}, 32'(NUM_LATCH - 1));
        check("hold_dbg_addr", dbg_addr, 32'(NUM_MEM - 1));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_start) extra++;
        end
        check("no_extra_tx", 32'(extra), 32'd0);
    endtask

    initial begin
        int lows;
        int found;
        reset = 1'b0; cmd_valid = 1'b0; cmd_code = 8'h00;
        halt_detected = 1'b0; tx_done = 1'b0; pc = 32'h0000_0010;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flags", {28'd0, busy, debug_on, stop_debug, cmd_ready}, 32'h3);
        check("rst_tx", {23'd0, tx_start, tx_data}, 32'd0);
        check("rst_sel", {25'd0, latch_sel}, 32'd0);
        check("rst_addr", dbg_addr, 32'd0);
        reset = 1'b1;

        // Dropped commands and stray tx_done while halted
        send_cmd(8'h68);
        send_cmd(8'h55);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("halted_idle", {29'd0, busy, stop_debug, tx_start}, 32'h2);

        // 1: plain dump
        push_dump(pc);
        send_cmd(8'h64);
        collect(TOTAL_BYTES);
        finish_checks();

        // 2: run then halt_detected after 50 cycles
        pc = 32'h0000_0400;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_code = 8'h63;
        @(negedge clk);
        cmd_valid = 1'b0;
        lows = 0;
        for (int i = 1; i <= 50; i++) begin
            if (i > 1) @(negedge clk);
            if (stop_debug == 1'b0) lows++;
            if (i == 50) halt_detected = 1'b1;
        end
        @(negedge clk);
        halt_detected = 1'b0;
        check("run_low_cycles", 32'(lows), 32'd50);
        check("halt_stop_busy", {30'd0, stop_debug, busy}, 32'h3);
        push_dump(pc);
        collect(TOTAL_BYTES);
        finish_checks();

        // 3: three single steps
        for (int s = 0; s < 3; s++) begin
            pc = 32'h0000_1000 + 32'(s * 4);
            @(negedge clk);
            cmd_valid = 1'b1; cmd_code = 8'h73;
            @(negedge clk);
            cmd_valid = 1'b0;
            check("step_low", {31'd0, stop_debug}, 32'd0);
            @(negedge clk);
            check("step_high_busy", {30'd0, stop_debug, busy}, 32'h3);
            push_dump(pc);
            collect(TOTAL_BYTES);
            finish_checks();
        end

        // 4: 'h' and halt_detected together give a single dump
        pc = 32'hDEAD_BEEF;
        send_cmd(8'h63);
        repeat (5) @(negedge clk);
        cmd_valid = 1'b1; cmd_code = 8'h68; halt_detected = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; halt_detected = 1'b0;
        push_dump(pc);
        collect(TOTAL_BYTES);
        finish_checks();

        // 5: 'c' held during a dump is refused until HALTED
        pc = 32'h0000_0020;
        push_dump(pc);
        send_cmd(8'h64);
        cmd_valid = 1'b1; cmd_code = 8'h63;
        check("busy_ready_low", {31'd0, cmd_ready}, 32'd0);
        collect(TOTAL_BYTES);
        finish_checks();
        check("held_c_taken", {31'd0, stop_debug}, 32'd0);
        cmd_valid = 1'b0;
        @(negedge clk);
        halt_detected = 1'b1;
        @(negedge clk);
        halt_detected = 1'b0;
        push_dump(pc);
        collect(TOTAL_BYTES);
        finish_checks();

        // 6: reset in the middle of a dump
        pc = 32'h0000_0030;
        push_dump(pc);
        send_cmd(8'h64);
        collect(37);
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (tx_start) found = 1;
        end
        check("reset_wait_txstart", 32'(found), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("async_tx_start", {31'd0, tx_start}, 32'd0);
        check("async_flags", {28'd0, busy, debug_on, stop_debug, cmd_ready}, 32'h3);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        check("post_reset_sel", {25'd0, latch_sel}, 32'd0);
        pc = 32'h1234_5678;
        push_dump(pc);
        send_cmd(8'h64);
        collect(TOTAL_BYTES);
        finish_checks();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
